// File: rtl/seven_seg_pkg.sv
// Shared types, constants and nibble/anode helpers for the four-digit seven-segment scanner.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] AN_ALL_OFF = 4'b1111;

  typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

  function automatic logic [3:0] nibble_at(input logic [15:0] word, input digit_idx_t idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] anode_sel(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

  // True when the indexed nibble and every nibble above it are zero.
  function automatic logic upper_zero(input logic [15:0] word, input digit_idx_t idx);
    logic [15:0] shifted;
    shifted = word >> {idx, 2'b00};
    return (shifted == 16'h0000);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running 0..PRESCALE-1 counter; Tick is high for the single cycle the count sits at PRESCALE-1.
module scan_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic Clock,
  input  logic Reset,
  output logic Tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  assign Tick = (count == LAST);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (Tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed 4-digit hex scanner: each digit's nibble and active-low anode are registered for PRESCALE cycles.
// Optional leading-zero blanking of digits 1..3 when LEADING_ZERO_BLANK_EN is defined.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Load,
  input  logic [15:0] Value,
  input  logic        Enable,
  output logic        X3,
  output logic        X2,
  output logic        X1,
  output logic        X0,
  output logic [3:0]  AN
);

  logic        tick;
  digit_idx_t  idx;
  logic [15:0] disp;
  logic [3:0]  x_q;
  logic [3:0]  an_q;
  logic [3:0]  x_d;
  logic [3:0]  an_d;

  scan_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .Clock(Clock),
    .Reset(Reset),
    .Tick (tick)
  );

  // Reads the pre-load register, so a Load on a tick edge shows from the next slot.
  always_comb begin
    x_d  = nibble_at(disp, idx);
    an_d = Enable ? anode_sel(idx) : AN_ALL_OFF;
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx != '0) && upper_zero(disp, idx)) begin
      an_d = AN_ALL_OFF;
    end
`endif
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      disp <= 16'h0000;
    end else if (Load) begin
      disp <= Value;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      idx  <= '0;
      x_q  <= 4'h0;
      an_q <= AN_ALL_OFF;
    end else if (tick) begin
      x_q  <= x_d;
      an_q <= an_d;
      idx  <= idx + digit_idx_t'(1);
    end
  end

  assign X3 = x_q[3];
  assign X2 = x_q[2];
  assign X1 = x_q[1];
  assign X0 = x_q[0];
  assign AN = an_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner at PRESCALE=4: vector table, directed corner sequences, randomized run vs reference model.
module tb_seven_seg_scanner;

  localparam int P = 4;

  logic        Clock;
  logic        Reset;
  logic        Load;
  logic [15:0] Value;
  logic        Enable;
  logic        X3, X2, X1, X0;
  logic [3:0]  AN;
  logic [3:0]  xo;

  assign xo = {X3, X2, X1, X0};

  seven_seg_scanner #(
    .PRESCALE(P)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Load  (Load),
    .Value (Value),
    .Enable(Enable),
    .X3    (X3),
    .X2    (X2),
    .X1    (X1),
    .X0    (X0),
    .AN    (AN)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  // Reference model: edges counted since reset release; every P-th edge is a slot
  // boundary that shows digit (slot-1) mod 4 from the register as it stood before that edge.
  int          edges;
  logic [15:0] mreg;
  logic [3:0]  exp_x;
  logic [3:0]  exp_an;

  typedef struct {
    logic        ld;
    logic [15:0] val;
    logic        en;
    logic [3:0]  ex;
    logic [3:0]  ean;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    edges  = 0;
    mreg   = 16'h0000;
    exp_x  = 4'h0;
    exp_an = 4'hF;
  endtask

  task automatic model_edge(input logic ld, input logic [15:0] v, input logic en);
    int          d;
    logic        blank;
    logic [15:0] upper;
    edges++;
    if (edges % P == 0) begin
      d      = ((edges / P) - 1) % 4;
      exp_x  = mreg[4*d +: 4];
      blank  = !en;
      upper  = mreg >> (4 * d);
      if (LZB && d != 0 && upper == 16'h0000) blank = 1'b1;
      exp_an = blank ? 4'hF : ~(4'b0001 << d);
    end
    if (ld) mreg = v;
  endtask

  task automatic drive_cycle(input logic ld, input logic [15:0] v, input logic en);
    Load   = ld;
    Value  = v;
    Enable = en;
    @(posedge Clock);
    model_edge(ld, v, en);
    #1;
    chk("model_x", xo, exp_x);
    chk("model_an", AN, exp_an);
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 16'h0000, en);
  endtask

  // Asserted away from any clock edge; outputs must clear without an edge.
  task automatic do_reset();
    Reset = 1'b1;
    #1;
    chk("reset_x", xo, 4'h0);
    chk("reset_an", AN, 4'hF);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] rv;
    logic        rl;
    logic        re;

    tbl[0]  = '{1'b1, 16'h1234, 1'b1, 4'h0, 4'b1111};
    tbl[1]  = '{1'b0, 16'h0000, 1'b1, 4'h0, 4'b1111};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 4'h0, 4'b1111};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 4'h4, 4'b1110};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 4'h4, 4'b1110};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 4'h4, 4'b1110};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 4'h4, 4'b1110};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 4'h3, 4'b1101};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 4'h3, 4'b1101};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 4'h3, 4'b1101};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 4'h3, 4'b1101};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 4'h2, 4'b1011};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 4'h2, 4'b1011};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 4'h2, 4'b1011};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 4'h2, 4'b1011};
    tbl[15] = '{1'b0, 16'h0000, 1'b1, 4'h1, 4'b0111};
    tbl[16] = '{1'b0, 16'h0000, 1'b1, 4'h1, 4'b0111};
    tbl[17] = '{1'b0, 16'h0000, 1'b1, 4'h1, 4'b0111};
    tbl[18] = '{1'b0, 16'h0000, 1'b1, 4'h1, 4'b0111};
    tbl[19] = '{1'b0, 16'h0000, 1'b1, 4'h4, 4'b1110};

    Reset  = 1'b1;
    Load   = 1'b0;
    Value  = 16'h0000;
    Enable = 1'b1;
    model_reset();
    do_reset();

    // Basic scan of 16'h1234, one row per edge after reset release.
    for (int i = 0; i < 20; i++) begin
      drive_cycle(tbl[i].ld, tbl[i].val, tbl[i].en);
      chk($sformatf("tbl%0d_x", i), xo, tbl[i].ex);
      chk($sformatf("tbl%0d_an", i), AN, tbl[i].ean);
    end

    // Load coincident with the digit-1 tick: old nibble shown, new value afterwards.
    idle(3, 1'b1);
    drive_cycle(1'b1, 16'hABCD, 1'b1);
    chk("ld_tick_old_x", xo, 4'h3);
    chk("ld_tick_old_an", AN, 4'b1101);
    idle(4, 1'b1);
    chk("ld_new_d2_x", xo, 4'hB);
    chk("ld_new_d2_an", AN, 4'b1011);
    idle(4, 1'b1);
    chk("ld_new_d3_x", xo, 4'hA);
    chk("ld_new_d3_an", AN, 4'b0111);
    idle(4, 1'b1);
    chk("ld_new_d0_x", xo, 4'hD);
    chk("ld_new_d0_an", AN, 4'b1110);

    // One full refresh with Enable low: every slot dark, digits keep advancing.
    idle(4, 1'b0);
    chk("dis_d1_an", AN, 4'b1111);
    chk("dis_d1_x", xo, 4'hC);
    idle(4, 1'b0);
    chk("dis_d2_an", AN, 4'b1111);
    idle(4, 1'b0);
    chk("dis_d3_an", AN, 4'b1111);
    idle(4, 1'b0);
    chk("dis_d0_an", AN, 4'b1111);
    chk("dis_d0_x", xo, 4'hD);
    idle(4, 1'b1);
    chk("reen_d1_x", xo, 4'hC);
    chk("reen_d1_an", AN, 4'b1101);

    // Reset mid-slot, then the first tick lands 4 edges after release on digit 0.
    idle(2, 1'b1);
    do_reset();
    drive_cycle(1'b1, 16'h5678, 1'b1);
    idle(2, 1'b1);
    chk("post_rst_e3_an", AN, 4'b1111);
    chk("post_rst_e3_x", xo, 4'h0);
    idle(1, 1'b1);
    chk("post_rst_e4_x", xo, 4'h8);
    chk("post_rst_e4_an", AN, 4'b1110);

    // Leading-zero behaviour for 16'h0050 (index now at 1).
    drive_cycle(1'b1, 16'h0050, 1'b1);
    idle(3, 1'b1);
    chk("lz50_d1_x", xo, 4'h5);
    chk("lz50_d1_an", AN, 4'b1101);
    idle(4, 1'b1);
    chk("lz50_d2_x", xo, 4'h0);
    chk("lz50_d2_an", AN, LZB ? 4'b1111 : 4'b1011);
    idle(4, 1'b1);
    chk("lz50_d3_an", AN, LZB ? 4'b1111 : 4'b0111);
    idle(4, 1'b1);
    chk("lz50_d0_x", xo, 4'h0);
    chk("lz50_d0_an", AN, 4'b1110);

    // All-zero value: only digit 0 stays lit when blanking is built in.
    drive_cycle(1'b1, 16'h0000, 1'b1);
    idle(3, 1'b1);
    chk("lz0_d1_an", AN, LZB ? 4'b1111 : 4'b1101);
    idle(4, 1'b1);
    chk("lz0_d2_an", AN, LZB ? 4'b1111 : 4'b1011);
    idle(4, 1'b1);
    chk("lz0_d3_an", AN, LZB ? 4'b1111 : 4'b0111);
    idle(4, 1'b1);
    chk("lz0_d0_x", xo, 4'h0);
    chk("lz0_d0_an", AN, 4'b1110);

    // Randomized traffic with sparse loads, leading-zero-heavy values, Enable drops and resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(199, 0) == 0) do_reset();
      rv = 16'($urandom);
      case ($urandom_range(3, 0))
        0: rv = rv & 16'h00FF;
        1: rv = rv & 16'h000F;
        2: rv = rv & 16'h0FFF;
        default: ;
      endcase
      rl = ($urandom_range(5, 0) == 0);
      re = ($urandom_range(4, 0) != 0);
      drive_cycle(rl, rv, re);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
